// File: rtl/spm_param.sv
// spm_param: serial-parallel carry-save multiplier with start/busy/done handshake.
// Build option SPM_SIGNED_EN selects two's-complement operands (default: unsigned).
`default_nettype none

module spm_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic               p_bit,
  output logic               p_bit_vld
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q;
  logic [PW-1:0]    ysh_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] s_q, c_q;
  logic [WIDTH-1:0] s_d, c_d;
  logic             done_q, p_bit_q, vld_q;
  logic [PW-1:0]    p_q;

  logic             start_ok;
  logic             run;
  logic             last;
  logic             ybit;
  logic [PW-1:0]    yload;
  logic             top_sin;

  assign start_ok = (state_q == S_IDLE) && start;
  assign run      = (state_q == S_RUN);
  assign last     = (cnt_q == CW'(PW - 1));
  assign ybit     = ysh_q[0];

`ifdef SPM_SIGNED_EN
  assign yload   = {{WIDTH{y[WIDTH-1]}}, y};
  // The inverted top partial products each carry a hidden -1; their sum
  // mod 2^PW is +2^(WIDTH-1), injected once into the top cell's free input.
  assign top_sin = (cnt_q == '0);
`else
  assign yload   = {{WIDTH{1'b0}}, y};
  assign top_sin = 1'b0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic pp, sin;
    if (i == WIDTH - 1) begin : g_top
`ifdef SPM_SIGNED_EN
      assign pp  = ~(x_q[i] & ybit);
`else
      assign pp  = x_q[i] & ybit;
`endif
      assign sin = top_sin;
    end else begin : g_mid
      assign pp  = x_q[i] & ybit;
      assign sin = s_q[i+1];
    end
    assign s_d[i] = pp ^ sin ^ c_q[i];
    assign c_d[i] = (pp & sin) | (pp & c_q[i]) | (sin & c_q[i]);
  end

  always_comb begin
    state_d = state_q;
    if (start_ok)        state_d = S_RUN;
    else if (run && last) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      ysh_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      p_q     <= '0;
      p_bit_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= run && last;
      vld_q   <= run;
      p_bit_q <= run ? s_d[0] : 1'b0;
      if (start_ok) begin
        x_q   <= x;
        ysh_q <= yload;
        cnt_q <= '0;
        s_q   <= '0;
        c_q   <= '0;
      end else if (run) begin
        ysh_q <= {1'b0, ysh_q[PW-1:1]};
        cnt_q <= cnt_q + CW'(1);
        s_q   <= s_d;
        c_q   <= c_d;
        p_q   <= {s_d[0], p_q[PW-1:1]};
      end
    end
  end

  assign busy      = run;
  assign done      = done_q;
  assign p         = p_q;
  assign p_bit     = p_bit_q;
  assign p_bit_vld = vld_q;

endmodule

`default_nettype wire
